// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, score fields, directions and screen geometry
package pong_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    OVER  = 2'b11
  } state_t;
  localparam int OPP_HI = 7;
  localparam int OPP_LO = 4;
  localparam int PLY_HI = 3;
  localparam int PLY_LO = 0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_LEFT  = 1'b0;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BALL_X0  = SCREEN_W / 2;
  localparam int BALL_Y0  = SCREEN_H / 2;
endpackage

// File: rtl/pong_tick_timer.sv
// pong_tick_timer: 8-bit loadable down-counter that parks at zero
module pong_tick_timer (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic [7:0] load_val,
  output logic       zero
);
  logic [7:0] cnt;
  // load wins over counting; the counter stops at zero rather than wrapping
  always_ff @(posedge clk_div)
    if (!rst_n) cnt <= 8'd0;
    else if (load) cnt <= load_val;
    else if (en && cnt != 8'd0) cnt <= cnt - 8'd1;
  assign zero = (cnt == 8'd0);
endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match FSM, score and serve pacing; PONG_MATCH_AUTO_RESTART_EN enables timed restart from OVER
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 30,
  parameter int OVER_HOLD   = 120
) (
  input  logic       clk_div,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       player_point,
  input  logic       opp_point,
  output logic [7:0] score,
  output logic       ball_enable,
  output logic       ball_recenter,
  output logic       serve_dir,
  output logic [1:0] state,
  output logic       game_over,
  output logic       winner
);
`ifdef PONG_MATCH_AUTO_RESTART_EN
  localparam logic AUTO = 1'b1;
`else
  localparam logic AUTO = 1'b0;
`endif
  state_t     st, nxt_st;
  logic       start_prev, start_rise, go_serve;
  logic [7:0] nxt_score;
  logic       nxt_dir, nxt_winner;
  logic [3:0] ply_inc, opp_inc;
  logic       t_load, t_en, t_zero;
  logic [7:0] t_val;
  pong_tick_timer u_timer (
    .clk_div (clk_div),
    .rst_n   (rst_n),
    .load    (t_load),
    .en      (t_en),
    .load_val(t_val),
    .zero    (t_zero)
  );
  // next-state, score and serve bookkeeping; go_serve marks every (re)entry to SERVE
  always_comb begin
    start_rise = start_btn & ~start_prev;
    ply_inc    = score[PLY_HI:PLY_LO] + 4'd1;
    opp_inc    = score[OPP_HI:OPP_LO] + 4'd1;
    nxt_st     = st;
    nxt_score  = score;
    nxt_dir    = serve_dir;
    nxt_winner = winner;
    go_serve   = 1'b0;
    case (st)
      IDLE: if (start_rise) begin
        go_serve  = 1'b1;
        nxt_score = 8'h00;
      end
      SERVE: if (t_zero) nxt_st = PLAY;
      PLAY: if (player_point && opp_point) go_serve = 1'b1;
      else if (player_point) begin
        nxt_score[PLY_HI:PLY_LO] = ply_inc;
        nxt_dir = DIR_LEFT;
        if (ply_inc == 4'(WIN_SCORE)) begin
          nxt_st     = OVER;
          nxt_winner = 1'b0;
        end else go_serve = 1'b1;
      end else if (opp_point) begin
        nxt_score[OPP_HI:OPP_LO] = opp_inc;
        nxt_dir = DIR_RIGHT;
        if (opp_inc == 4'(WIN_SCORE)) begin
          nxt_st     = OVER;
          nxt_winner = 1'b1;
        end else go_serve = 1'b1;
      end
      OVER: if (start_rise || (AUTO && t_zero)) begin
        go_serve  = 1'b1;
        nxt_score = 8'h00;
      end
      default: nxt_st = IDLE;
    endcase
    if (go_serve) nxt_st = SERVE;
    t_load = go_serve || (AUTO && nxt_st == OVER && st != OVER);
    t_val  = go_serve ? 8'(SERVE_DELAY - 1) : 8'(OVER_HOLD - 1);
    t_en   = (st == SERVE) || (AUTO && st == OVER);
  end
  // state and all outputs register together so they always agree
  always_ff @(posedge clk_div)
    if (!rst_n) begin
      st            <= IDLE;
      score         <= 8'h00;
      ball_enable   <= 1'b0;
      ball_recenter <= 1'b0;
      serve_dir     <= DIR_RIGHT;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      start_prev    <= 1'b1;
    end else begin
      st            <= nxt_st;
      score         <= nxt_score;
      ball_enable   <= (nxt_st == PLAY);
      ball_recenter <= go_serve;
      serve_dir     <= nxt_dir;
      game_over     <= (nxt_st == OVER);
      winner        <= nxt_winner;
      start_prev    <= start_btn;
    end
  assign state = st;
endmodule

// File: doc/pong_match_ctrl.md
Name: pong_match_ctrl

Overview:
Match-level controller sitting between the ball/paddle physics stage and the VGA renderer. It consumes per-point events from the physics stage and owns the packed score and serve pacing. It gates ball motion through a start/serve/play/game-over state machine. It runs on the frame-rate clock, so one clk_div edge is one game tick.

Parameters:
WIN_SCORE, 7, points needed to win; legal range 1..15
SERVE_DELAY, 30, ticks the ball is held centred before each serve; legal range 1..255
OVER_HOLD, 120, ticks spent in OVER before auto-restart; used only with the optional feature; legal range 1..255

Ports:
clk_div  in  1  frame-rate game clock
rst_n  in  1  reset, synchronous, active-low
start_btn  in  1  start/restart request, level input
player_point  in  1  one-tick pulse: player scored (ball exited the left edge)
opp_point  in  1  one-tick pulse: opponent scored (ball exited the right edge)
score  out  8  [7:4] opponent points, [3:0] player points
ball_enable  out  1  physics stage may move the ball
ball_recenter  out  1  one-tick pulse: physics stage reloads the ball to screen centre
serve_dir  out  1  initial ball x direction; 1 = right, 0 = left
state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER
game_over  out  1  high while in OVER
winner  out  1  valid while game_over; 0 = player, 1 = opponent

Behaviour:
- Clocking and outputs: all logic sits on posedge clk_div. All outputs are registered and update on the same edge as the state register.
- Reset (rst_n low at an edge) has priority over everything, including mid-match. Reset values:
  - state=IDLE, score=0x00, ball_enable=0, ball_recenter=0
  - serve_dir=1, game_over=0, winner=0, timer=0
  - start_prev=1, so a button held through reset does not start a game.
- Start edge: start_rise = start_btn & ~start_prev; start_prev <= start_btn every tick.
- IDLE: ball_enable=0. On start_rise: go to SERVE, score<=0, timer<=SERVE_DELAY-1, ball_recenter<=1 for exactly one tick.
- SERVE: ball_enable=0; timer decrements once per tick. At timer==0: go to PLAY with ball_enable<=1 on that same edge. The ball is therefore frozen for exactly SERVE_DELAY ticks after entry.
- PLAY: ball_enable=1.
  - player_point only: player nibble +1, serve_dir<=0.
  - opp_point only: opponent nibble +1, serve_dir<=1.
  - After either single point:
    - If the incremented nibble equals WIN_SCORE: go to OVER, game_over<=1, winner<=scorer, ball_enable<=0, no recenter.
    - Otherwise: go to SERVE, timer reload, ball_recenter pulse, ball_enable<=0.
  - Both points asserted in the same tick: neither is counted, serve_dir is unchanged, go to SERVE with recenter.
- Point pulses in IDLE, SERVE or OVER are ignored.
- Nibbles never exceed WIN_SCORE, so there is no wrap.
- OVER: ball_enable=0; score and winner are held. On start_rise: behave as the IDLE start, and game_over<=0.
- start_btn during SERVE or PLAY has no effect.
- Unreachable state encodings recover to IDLE on the next tick.

Optional Feature:
PONG_MATCH_AUTO_RESTART_EN
- Defined: on entry to OVER, timer<=OVER_HOLD-1. At timer==0 the block behaves as a start_rise: go to SERVE, score<=0, game_over<=0, recenter pulse. A start_rise during OVER still restarts immediately.
- Undefined: OVER is held until a start_rise; the OVER_HOLD parameter is unused.

Decomposition:
- Shared package pong_pkg holds:
  - state encoding constants (IDLE/SERVE/PLAY/OVER)
  - score nibble field positions (OPP_HI=7, OPP_LO=4, PLY_HI=3, PLY_LO=0)
  - direction constants DIR_RIGHT=1, DIR_LEFT=0
  - screen geometry constants shared with physics and render.
- One sub-module is natural: pong_tick_timer, an 8-bit loadable down-counter with load, enable and a zero flag. It is used for both SERVE_DELAY and OVER_HOLD.

Test Plan:
- Reset held with start_btn=1, then rst_n=1 with start_btn kept high for 5 ticks -> state stays 00. Drop start_btn, then raise it -> next tick state=01, ball_recenter=1 for one tick, score=0x00.
- After start -> ball_enable=0 for exactly 30 ticks, then state=10 and ball_enable=1 on tick 31.
- In PLAY, one player_point pulse -> score=0x01, serve_dir=0, state=01, ball_recenter high for one tick, ball_enable=0.
- Seven opp_point pulses, each in PLAY -> score=0x70, state=11, game_over=1, winner=1, ball_enable=0. Further point pulses leave score=0x70.
- In PLAY, player_point and opp_point in the same tick -> score unchanged, state=01, recenter pulse, serve_dir unchanged. Separately, rst_n low mid-PLAY -> all outputs at reset values on the next tick.
- With PONG_MATCH_AUTO_RESTART_EN, OVER_HOLD=120 -> 120 ticks in OVER, then state=01, score=0x00, game_over=0. Without the macro -> still in OVER after 500 ticks.
